// File: rtl/hazard_int_controller.sv
// -----------------------------------------------------------------------------
// hazard_int_controller
//
// Central sequencer for the 5-stage pipeline:
//   * load-use hazard detection (stalls PC and IF/ID, injects one ID/EX bubble)
//   * front-end flush on a taken jump/call/ret resolved in EX
//   * hardware interrupt entry: drain, push PC, push flags, load vector
//   * hardware RTI: pop flags, pop PC
// Forced stack operations are issued to the memory stage with force_push_o /
// force_pop_o held until mem_ack_i.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ex_mem_read_i, ex_rd_i   EX instruction is a load/pop, and its destination
//   id_rs1_i, id_rs2_i       ID source registers
//   id_uses_rs1/2_i          ID instruction actually reads rs1/rs2
//   id_is_rti_i              ID instruction is RTI
//   branch_taken_i           EX resolved a taken control transfer
//   int_req_i                interrupt request (level, sampled every clock)
//   mem_ack_i                memory stage finished the forced push/pop
//   pc_write_o, if_id_write_o, clear_instruction_o, id_ex_flush_o
//                            pipeline register controls
//   force_push_o, force_pop_o, force_src_sel_o (0 = PC, 1 = flags)
//                            forced stack port
//   flags_restore_o, pc_load_pop_o, pc_load_vector_o
//                            load selects for flags/PC
//   int_ack_o                single-cycle acknowledge at vector load
//   busy_o                   sequencer is not in RUN
// -----------------------------------------------------------------------------
module hazard_int_controller #(
  parameter int REG_ADDR_W   = 3,
  parameter int DRAIN_CYCLES = 2   // legal 1..7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_is_rti_i,
  input  logic                  branch_taken_i,
  input  logic                  int_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  clear_instruction_o,
  output logic                  id_ex_flush_o,
  output logic                  force_push_o,
  output logic                  force_pop_o,
  output logic                  force_src_sel_o,
  output logic                  flags_restore_o,
  output logic                  pc_load_pop_o,
  output logic                  pc_load_vector_o,
  output logic                  int_ack_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_INT_DRAIN,
    ST_INT_PUSH_PC,
    ST_INT_PUSH_FLAGS,
    ST_INT_VECTOR,
    ST_RTI_POP_FLAGS,
    ST_RTI_POP_PC
  } state_e;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic       int_pending_q, int_pending_d;

  logic stall;

  // Load-use hazard: the value the ID instruction needs is still being read
  // from memory by the instruction in EX.
  assign stall = ex_mem_read_i &
                 ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                  (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // Sequences only start on a cycle the ID instruction would advance.
        if (!branch_taken_i && !stall) begin
          if (int_pending_q) begin
            state_d     = ST_INT_DRAIN;
            drain_cnt_d = 3'd0;
          end else if (id_is_rti_i) begin
            state_d = ST_RTI_POP_FLAGS;
          end
        end
      end
      ST_INT_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_cnt_q == DRAIN_LAST) state_d = ST_INT_PUSH_PC;
      end
      ST_INT_PUSH_PC:    if (mem_ack_i) state_d = ST_INT_PUSH_FLAGS;
      ST_INT_PUSH_FLAGS: if (mem_ack_i) state_d = ST_INT_VECTOR;
      ST_INT_VECTOR:     state_d = ST_RUN;
      ST_RTI_POP_FLAGS:  if (mem_ack_i) state_d = ST_RTI_POP_PC;
      ST_RTI_POP_PC:     if (mem_ack_i) state_d = ST_RUN;
      default:           state_d = ST_RUN;
    endcase
  end

  // A new request wins over the clear issued with int_ack.
  assign int_pending_d = int_req_i | (int_pending_q & (state_q != ST_INT_VECTOR));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= 3'd0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      int_pending_q <= int_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Stall and the mem_ack-cycle loads must act in the same
  // cycle, so outputs are decoded from state plus live inputs.
  // ---------------------------------------------------------------------------
  logic pc_write, if_id_write, clear_instruction, id_ex_flush;
  logic force_push, force_pop, force_src_sel, flags_restore;
  logic pc_load_pop, pc_load_vector, int_ack, busy;

  always_comb begin
    pc_write          = 1'b0;
    if_id_write       = 1'b0;
    clear_instruction = 1'b0;
    id_ex_flush       = 1'b0;
    force_push        = 1'b0;
    force_pop         = 1'b0;
    force_src_sel     = 1'b0;
    flags_restore     = 1'b0;
    pc_load_pop       = 1'b0;
    pc_load_vector    = 1'b0;
    int_ack           = 1'b0;
    busy              = 1'b0;
    if (state_q == ST_RUN) begin
      if (branch_taken_i) begin
        // A taken jump squashes the wrong-path instruction, so any hazard
        // it had is irrelevant.
        pc_write          = 1'b1;
        if_id_write       = 1'b1;
        clear_instruction = 1'b1;
        id_ex_flush       = 1'b1;
      end else if (stall) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        // RTI leaving for its pop sequence turns into a bubble itself.
        id_ex_flush = ~int_pending_q & id_is_rti_i;
      end
    end else begin
      busy              = 1'b1;
      clear_instruction = 1'b1;
      id_ex_flush       = 1'b1;
      unique case (state_q)
        // Let a late jump land so the pushed PC is the real resume point.
        ST_INT_DRAIN:      pc_write = branch_taken_i;
        ST_INT_PUSH_PC:    force_push = 1'b1;
        ST_INT_PUSH_FLAGS: begin
          force_push    = 1'b1;
          force_src_sel = 1'b1;
        end
        ST_INT_VECTOR: begin
          pc_write       = 1'b1;
          pc_load_vector = 1'b1;
          int_ack        = 1'b1;
        end
        ST_RTI_POP_FLAGS: begin
          force_pop     = 1'b1;
          force_src_sel = 1'b1;
          flags_restore = mem_ack_i;
        end
        ST_RTI_POP_PC: begin
          force_pop   = 1'b1;
          pc_write    = mem_ack_i;
          pc_load_pop = mem_ack_i;
        end
        default: ;
      endcase
    end
  end

  // Reset must silence every output immediately, not at the next edge.
  assign pc_write_o          = rst_ni & pc_write;
  assign if_id_write_o       = rst_ni & if_id_write;
  assign clear_instruction_o = rst_ni & clear_instruction;
  assign id_ex_flush_o       = rst_ni & id_ex_flush;
  assign force_push_o        = rst_ni & force_push;
  assign force_pop_o         = rst_ni & force_pop;
  assign force_src_sel_o     = rst_ni & force_src_sel;
  assign flags_restore_o     = rst_ni & flags_restore;
  assign pc_load_pop_o       = rst_ni & pc_load_pop;
  assign pc_load_vector_o    = rst_ni & pc_load_vector;
  assign int_ack_o           = rst_ni & int_ack;
  assign busy_o              = rst_ni & busy;

endmodule

// File: tb/tb_hazard_int_controller.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_int_controller. The reference model describes the
// controller as a queue of pending hardware operations: an interrupt enqueues
// its drain cycles, two pushes and the vector load; RTI enqueues two pops.
// Each cycle the expected control word is derived from the queue head.
// -----------------------------------------------------------------------------
module tb_hazard_int_controller;

  localparam int W  = 3;
  localparam int DC = 2;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         ex_mem_read = 1'b0;
  logic [W-1:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic         id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_is_rti = 1'b0;
  logic         branch_taken = 1'b0, int_req = 1'b0, mem_ack = 1'b0;

  logic pc_write_o, if_id_write_o, clear_instruction_o, id_ex_flush_o;
  logic force_push_o, force_pop_o, force_src_sel_o, flags_restore_o;
  logic pc_load_pop_o, pc_load_vector_o, int_ack_o, busy_o;

  hazard_int_controller #(.REG_ADDR_W(W), .DRAIN_CYCLES(DC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .ex_mem_read_i      (ex_mem_read),
    .ex_rd_i            (ex_rd),
    .id_rs1_i           (id_rs1),
    .id_rs2_i           (id_rs2),
    .id_uses_rs1_i      (id_uses_rs1),
    .id_uses_rs2_i      (id_uses_rs2),
    .id_is_rti_i        (id_is_rti),
    .branch_taken_i     (branch_taken),
    .int_req_i          (int_req),
    .mem_ack_i          (mem_ack),
    .pc_write_o         (pc_write_o),
    .if_id_write_o      (if_id_write_o),
    .clear_instruction_o(clear_instruction_o),
    .id_ex_flush_o      (id_ex_flush_o),
    .force_push_o       (force_push_o),
    .force_pop_o        (force_pop_o),
    .force_src_sel_o    (force_src_sel_o),
    .flags_restore_o    (flags_restore_o),
    .pc_load_pop_o      (pc_load_pop_o),
    .pc_load_vector_o   (pc_load_vector_o),
    .int_ack_o          (int_ack_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, clear, flush, push, pop, src, flags_restore,
  //  pc_load_pop, pc_load_vector, int_ack, busy}
  logic [11:0] dut_vec;
  assign dut_vec = {pc_write_o, if_id_write_o, clear_instruction_o, id_ex_flush_o,
                    force_push_o, force_pop_o, force_src_sel_o, flags_restore_o,
                    pc_load_pop_o, pc_load_vector_o, int_ack_o, busy_o};

  typedef enum int {OP_DRAIN, OP_PUSH_PC, OP_PUSH_FL, OP_VEC, OP_POP_FL, OP_POP_PC} op_e;
  op_e ops[$];
  bit  pend;

  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0, ack_cnt = 0;
  int auto_lat = 0, req_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit hazard();
    return ex_mem_read && ((id_uses_rs1 && id_rs1 == ex_rd) ||
                           (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [11:0] model_out();
    logic pw, ifw, clr, fl, fpu, fpo, src, fr, plp, plv, ack, bsy;
    {pw, ifw, clr, fl, fpu, fpo, src, fr, plp, plv, ack, bsy} = '0;
    if (!rst_ni) return '0;
    if (ops.size() == 0) begin
      if (branch_taken) {pw, ifw, clr, fl} = 4'b1111;
      else if (hazard()) fl = 1'b1;
      else begin
        pw  = 1'b1;
        ifw = 1'b1;
        fl  = !pend && id_is_rti;
      end
    end else begin
      bsy = 1'b1; clr = 1'b1; fl = 1'b1;
      case (ops[0])
        OP_DRAIN:   pw = branch_taken;
        OP_PUSH_PC: fpu = 1'b1;
        OP_PUSH_FL: begin fpu = 1'b1; src = 1'b1; end
        OP_VEC:     begin pw = 1'b1; plv = 1'b1; ack = 1'b1; end
        OP_POP_FL:  begin fpo = 1'b1; src = 1'b1; fr = mem_ack; end
        OP_POP_PC:  begin fpo = 1'b1; pw = mem_ack; plp = mem_ack; end
        default: ;
      endcase
    end
    return {pw, ifw, clr, fl, fpu, fpo, src, fr, plp, plv, ack, bsy};
  endfunction

  function automatic void model_advance();
    bit was_vec;
    was_vec = (ops.size() != 0) && (ops[0] == OP_VEC);
    if (ops.size() == 0) begin
      if (!branch_taken && !hazard()) begin
        if (pend) begin
          for (int i = 0; i < DC; i++) ops.push_back(OP_DRAIN);
          ops.push_back(OP_PUSH_PC);
          ops.push_back(OP_PUSH_FL);
          ops.push_back(OP_VEC);
        end else if (id_is_rti) begin
          ops.push_back(OP_POP_FL);
          ops.push_back(OP_POP_PC);
        end
      end
    end else if (ops[0] == OP_DRAIN || ops[0] == OP_VEC) begin
      void'(ops.pop_front());
    end else if (mem_ack) begin
      void'(ops.pop_front());
    end
    pend = int_req || (pend && !was_vec);
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    if (auto_lat > 0) begin
      if (force_push_o || force_pop_o) req_run++;
      else req_run = 0;
      mem_ack = (req_run == auto_lat);
    end
    #1;
    check(tag, dut_vec, model_out());
    busy_cnt += busy_o;
    ack_cnt  += int_ack_o;
    @(posedge clk);
    model_advance();
    if (auto_lat > 0 && mem_ack) req_run = 0;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_mem_read = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_rti = 0;
    branch_taken = 0; int_req = 0; mem_ack = 0;
  endtask

  initial begin
    bit found;
    // Reset: outputs forced low even with active-looking inputs.
    branch_taken = 1;
    int_req      = 1;
    #12;
    check("reset_outs", dut_vec, 12'h000);
    @(negedge clk);
    idle_inputs();
    rst_ni = 1;
    ops.delete();
    pend = 0;
    #1 check("reset_busy", busy_o, 0);
    @(negedge clk);
    cycle("idle");

    // Load-use stall on rs2, then release.
    ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1; id_rs1 = 5; id_uses_rs1 = 1;
    cycle("loaduse");
    ex_mem_read = 0;
    cycle("loaduse_after");
    ex_mem_read = 1; id_uses_rs2 = 0;
    cycle("no_stall");
    // Branch overrides stall.
    id_uses_rs2 = 1; branch_taken = 1;
    cycle("br_stall");
    idle_inputs();

    // Interrupt entry, ack in the third cycle of each push.
    auto_lat = 3; busy_cnt = 0; ack_cnt = 0;
    int_req = 1;
    cycle("int");
    int_req = 0;
    repeat (14) cycle("int");
    check("int_busy_cycles", busy_cnt, 9);
    check("int_ack_count", ack_cnt, 1);

    // RTI, ack in the second cycle of each pop.
    auto_lat = 2; busy_cnt = 0;
    id_is_rti = 1;
    cycle("rti");
    id_is_rti = 0;
    repeat (8) cycle("rti");
    check("rti_busy_cycles", busy_cnt, 4);

    // Interrupt raised during RTI's first pop.
    busy_cnt = 0; ack_cnt = 0;
    id_is_rti = 1;
    cycle("rti_int");
    id_is_rti = 0; int_req = 1;
    cycle("rti_int");
    int_req = 0;
    repeat (20) cycle("rti_int");
    check("rti_int_busy", busy_cnt, 4 + DC + 2 + 2 + 1);
    check("rti_int_ack_count", ack_cnt, 1);

    // Async reset in the middle of the flags push, with a request pending.
    auto_lat = 3; req_run = 0;
    int_req = 1;
    cycle("rst_seq");
    int_req = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (force_push_o && force_src_sel_o) found = 1;
      else cycle("rst_seq");
    end
    check("reach_push_flags", found, 1);
    int_req = 1;
    cycle("rst_pend");
    int_req = 0;
    #3 rst_ni = 0;
    #1 check("async_rst", dut_vec, 12'h000);
    ops.delete();
    pend = 0;
    req_run = 0; mem_ack = 0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1;
    #1 check("post_rst_busy", busy_o, 0);
    repeat (6) cycle("post_rst");

    // Randomized traffic.
    auto_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_rd        = W'($urandom_range(0, 3));
      id_rs1       = W'($urandom_range(0, 3));
      id_rs2       = W'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      id_is_rti    = ($urandom % 8) == 0;
      branch_taken = ($urandom % 5) == 0;
      int_req      = ($urandom % 20) == 0;
      mem_ack      = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
